// File: rtl/cpu_param.sv
// cpu_param: multicycle, width-parametrised lab CPU core (register file, shifter, ALU, flags, FSM).
// Optional multiplier enabled by defining CPU_MUL_EN (opcode 111/00 = MUL).
module cpu_param #(
    parameter int DATA_W   = 16,
    parameter bit IMM_SEXT = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              s_i,
    input  logic              load_i,
    input  logic [15:0]       in_i,
    output logic [DATA_W-1:0] out_o,
    output logic              N_o,
    output logic              V_o,
    output logic              Z_o,
    output logic              w_o
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WR_REG
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       ir_q;
    logic [15:0]       exIr_q;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              n_q, v_q, z_q;

    logic [2:0]        opcode, rn, rd, rm;
    logic [1:0]        op, sh;
    logic              isMovImm, isMovReg, isArith, isMvn, isCmp, isMul;
    logic [DATA_W-1:0] shB, aluRes, immExt;

    // exIr_q holds the instruction being executed, so IR can take a new word on the start edge
    assign opcode = exIr_q[15:13];
    assign op     = exIr_q[12:11];
    assign rn     = exIr_q[10:8];
    assign rd     = exIr_q[7:5];
    assign sh     = exIr_q[4:3];
    assign rm     = exIr_q[2:0];

    assign isMovImm = (opcode == 3'b110) && (op == 2'b10);
    assign isMovReg = (opcode == 3'b110) && (op == 2'b00);
    assign isArith  = (opcode == 3'b101);
    assign isMvn    = isArith && (op == 2'b11);
    assign isCmp    = isArith && (op == 2'b01);
`ifdef CPU_MUL_EN
    assign isMul    = (opcode == 3'b111) && (op == 2'b00);
`else
    assign isMul    = 1'b0;
`endif

    assign immExt = IMM_SEXT ? DATA_W'($signed(exIr_q[7:0])) : DATA_W'(exIr_q[7:0]);

    always_comb begin
        case (sh)
            2'b01:   shB = {b_q[DATA_W-2:0], 1'b0};
            2'b10:   shB = {1'b0, b_q[DATA_W-1:1]};
            2'b11:   shB = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
            default: shB = b_q;
        endcase
    end

    always_comb begin
        aluRes = shB;
        if (isArith) begin
            case (op)
                2'b00:   aluRes = a_q + shB;
                2'b01:   aluRes = a_q - shB;
                2'b10:   aluRes = a_q & shB;
                default: aluRes = ~shB;
            endcase
        end
`ifdef CPU_MUL_EN
        else if (isMul) begin
            aluRes = a_q * shB;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (s_i) state_d = S_DECODE;
            S_DECODE: begin
                if (isMovImm)                      state_d = S_WR_IMM;
                else if ((isArith && !isMvn) || isMul) state_d = S_LOAD_A;
                else if (isMovReg || isMvn)        state_d = S_LOAD_B;
                else                               state_d = S_WAIT;
            end
            S_WR_IMM: state_d = S_WAIT;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = isCmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_WAIT;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ir_q   <= '0;
            exIr_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (load_i) ir_q <= in_i;
                    if (s_i)    exIr_q <= ir_q;
                end
                S_WR_IMM: regs_q[rn] <= immExt;
                S_LOAD_A: a_q <= regs_q[rn];
                S_LOAD_B: b_q <= regs_q[rm];
                S_EXEC: begin
                    c_q <= aluRes;
                    if (isCmp) begin
                        z_q <= (aluRes == '0);
                        n_q <= aluRes[DATA_W-1];
                        v_q <= (a_q[DATA_W-1] != shB[DATA_W-1]) &&
                               (aluRes[DATA_W-1] != a_q[DATA_W-1]);
                    end
                end
                S_WR_REG: regs_q[rd] <= c_q;
                default: ;
            endcase
        end
    end

    assign out_o = c_q;
    assign N_o   = n_q;
    assign V_o   = v_q;
    assign Z_o   = z_q;
    assign w_o   = (state_q == S_WAIT);

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: directed vector table plus hand-written sequences for cpu_param
// (reset abort, IR lockout, same-edge load/start, optional CPU_MUL_EN multiplier).
module tb_cpu_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in = '0;
    logic [15:0] out, out2;
    logic        n, v, z, w;
    logic        n2, v2, z2, w2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cpu_param #(.DATA_W(16), .IMM_SEXT(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .s_i(s), .load_i(load), .in_i(in),
        .out_o(out), .N_o(n), .V_o(v), .Z_o(z), .w_o(w)
    );

    // Second copy with zero-extended immediates, driven by the same stimulus
    cpu_param #(.DATA_W(16), .IMM_SEXT(1'b0)) dutZext (
        .clk_i(clk), .reset_i(reset), .s_i(s), .load_i(load), .in_i(in),
        .out_o(out2), .N_o(n2), .V_o(v2), .Z_o(z2), .w_o(w2)
    );

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [15:0] out;
        logic [2:0]  nvz;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic loadInstr(input logic [15:0] instr);
        @(negedge clk);
        in   = instr;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Pulse s for one edge and count edges until w returns high (bounded)
    task automatic startAndWait(output int lat);
        @(negedge clk);
        s = 1'b1;
        @(posedge clk);
        #1;
        s = 1'b0;
        lat = 1;
        while (!w && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, output int lat);
        loadInstr(instr);
        startAndWait(lat);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;

        vecs[0]  = '{16'hD004, 3, 16'h0000, 3'b000};
        vecs[1]  = '{16'hC020, 5, 16'h0004, 3'b000};
        vecs[2]  = '{16'hD2F8, 3, 16'h0004, 3'b000};
        vecs[3]  = '{16'hC07A, 5, 16'hFFFC, 3'b000};
        vecs[4]  = '{16'hB824, 5, 16'hFFFF, 3'b000};
        vecs[5]  = '{16'hC011, 5, 16'h7FFF, 3'b000};
        vecs[6]  = '{16'hA801, 5, 16'h8000, 3'b110};
        vecs[7]  = '{16'hA800, 5, 16'h0000, 3'b001};
        vecs[8]  = '{16'hA0A1, 6, 16'h7FFE, 3'b001};
        vecs[9]  = '{16'hB3C0, 6, 16'h7FFC, 3'b001};
        vecs[10] = '{16'hA0E8, 6, 16'h7FFD, 3'b001};
        vecs[11] = '{16'h0000, 2, 16'h7FFD, 3'b001};
        vecs[12] = '{16'hC085, 5, 16'h7FFE, 3'b001};
        vecs[13] = '{16'hA7E7, 6, 16'hFFFA, 3'b001};
        vecs[14] = '{16'hC0C7, 5, 16'hFFFA, 3'b001};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset w", {31'b0, w}, 32'd1);
        checkOutput("reset out", {16'b0, out}, 32'h0);
        checkOutput("reset nvz", {29'b0, n, v, z}, 32'h0);

        // Immediate extension: sign vs zero
        applyStimulus(16'hD2F8, lat);
        checkOutput("movimm lat", lat, 3);
        applyStimulus(16'hC07A, lat);
        checkOutput("asr lat", lat, 5);
        checkOutput("asr sext out", {16'b0, out}, 32'hFFFC);
        checkOutput("asr zext out", {16'b0, out2}, 32'h007C);

        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].instr, lat);
            checkOutput($sformatf("vec%0d lat", i), lat, vecs[i].lat);
            checkOutput($sformatf("vec%0d out", i), {16'b0, out}, {16'b0, vecs[i].out});
            checkOutput($sformatf("vec%0d nvz", i), {29'b0, n, v, z}, {29'b0, vecs[i].nvz});
        end

        // MUL R4,R0,R1 with R0=3, R1=5
        applyStimulus(16'hD003, lat);
        applyStimulus(16'hD105, lat);
        applyStimulus(16'hE081, lat);
`ifdef CPU_MUL_EN
        checkOutput("mul lat", lat, 6);
        checkOutput("mul out", {16'b0, out}, 32'h000F);
        applyStimulus(16'hC044, lat);
        checkOutput("mul r4", {16'b0, out}, 32'h000F);
`else
        checkOutput("mul nop lat", lat, 2);
        checkOutput("mul nop out", {16'b0, out}, 32'hFFFA);
        applyStimulus(16'hC044, lat);
        checkOutput("mul nop r4", {16'b0, out}, 32'h7FFE);
`endif
        checkOutput("mul nvz", {29'b0, n, v, z}, 32'h1);

        // Reset in EXEC of ADD R5,R0,R1, with s/load also asserted
        loadInstr(16'hA0A1);
        @(negedge clk);
        s = 1'b1;
        @(posedge clk);
        #1;
        s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("exec busy w", {31'b0, w}, 32'd0);
        reset = 1'b1;
        s     = 1'b1;
        load  = 1'b1;
        in    = 16'hD1FF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        checkOutput("abort w", {31'b0, w}, 32'd1);
        checkOutput("abort out", {16'b0, out}, 32'h0);
        checkOutput("abort nvz", {29'b0, n, v, z}, 32'h0);
        startAndWait(lat);
        checkOutput("abort ir nop lat", lat, 2);
        applyStimulus(16'hC0C5, lat);
        checkOutput("abort r5", {16'b0, out}, 32'h0);

        // IR lockout: load pulses while busy are ignored
        loadInstr(16'hB824);
        @(negedge clk);
        s = 1'b1;
        @(posedge clk);
        #1;
        s    = 1'b0;
        in   = 16'hD1FF;
        load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load = 1'b0;
        lat = 4;
        while (!w && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("lockout lat", lat, 5);
        checkOutput("lockout out", {16'b0, out}, 32'hFFFF);
        startAndWait(lat);
        checkOutput("replay lat", lat, 5);
        checkOutput("replay out", {16'b0, out}, 32'hFFFF);

        // load and s on the same edge: old IR executes, new IR is kept
        loadInstr(16'hC041);
        in   = 16'hD17F;
        load = 1'b1;
        s    = 1'b1;
        @(posedge clk);
        #1;
        s    = 1'b0;
        load = 1'b0;
        lat = 1;
        while (!w && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("same-edge old lat", lat, 5);
        checkOutput("same-edge old out", {16'b0, out}, 32'hFFFF);
        startAndWait(lat);
        checkOutput("same-edge new lat", lat, 3);
        applyStimulus(16'hC041, lat);
        checkOutput("same-edge new r1", {16'b0, out}, 32'h007F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
